// File: rtl/beam_trigger_pkg.sv
// Shared widths, sample-word layout and beam delay rule for the beam power trigger.
package beam_trigger_pkg;

  localparam int unsigned NCHAN        = 8;
  localparam int unsigned NSAMP        = 8;
  localparam int unsigned SAMP_BITS    = 5;
  localparam int unsigned BEAMSUM_BITS = 8;
  localparam int unsigned SQ_BITS      = 15;
  localparam int unsigned POWER_BITS   = 18;

  // word[c][s] is channel c, sample s (sample 0 oldest), two's complement
  typedef logic [NCHAN-1:0][NSAMP-1:0][SAMP_BITS-1:0] word_t;
  typedef logic [POWER_BITS-1:0] power_t;

  localparam power_t THRESH_RESET = '1;

  function automatic int unsigned beam_delay(input int unsigned b, input int unsigned c);
    return (b * c) % NSAMP;
  endfunction

endpackage

// File: rtl/beam_trigger_beam_power.sv
// One delay-and-sum beam: sum, square and 8-sample window accumulate, one register per stage.
module beam_power
  import beam_trigger_pkg::*;
#(
  parameter int unsigned BEAM = 0
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  word_t  cur_word,
  input  word_t  prev_word,
  output power_t power
);

  logic signed [SAMP_BITS-1:0]    tap   [NSAMP][NCHAN];
  logic signed [BEAMSUM_BITS-1:0] sum_c [NSAMP];
  logic signed [BEAMSUM_BITS-1:0] sum_q [NSAMP];
  logic        [SQ_BITS-1:0]      sq_q  [NSAMP];
  power_t                         power_c;

  // Delayed taps that fall before sample 0 reach into the previous word
  for (genvar s = 0; s < NSAMP; s++) begin : g_samp
    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      localparam int K = s - int'(beam_delay(BEAM, c));
      if (K >= 0) begin : g_cur
        assign tap[s][c] = cur_word[c][K];
      end else begin : g_prev
        assign tap[s][c] = prev_word[c][K + NSAMP];
      end
    end
  end

  always_comb begin
    for (int unsigned s = 0; s < NSAMP; s++) begin
      sum_c[s] = '0;
      for (int unsigned c = 0; c < NCHAN; c++) begin
        sum_c[s] = sum_c[s] + BEAMSUM_BITS'(tap[s][c]);
      end
    end
  end

  always_comb begin
    power_c = '0;
    for (int unsigned s = 0; s < NSAMP; s++) begin
      power_c = power_c + POWER_BITS'(sq_q[s]);
    end
  end

  // Square is taken in 15-bit context; (-128)^2 = 16384 still fits unsigned
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NSAMP; s++) begin
        sum_q[s] <= '0;
        sq_q[s]  <= '0;
      end
      power <= '0;
    end else begin
      for (int unsigned s = 0; s < NSAMP; s++) begin
        sum_q[s] <= sum_c[s];
        sq_q[s]  <= SQ_BITS'(sum_q[s]) * SQ_BITS'(sum_q[s]);
      end
      power <= power_c;
    end
  end

endmodule

// File: rtl/beam_power_trigger.sv
// Per-beam power trigger: input/previous-word capture, staged thresholds and strict compare.
module beam_power_trigger
  import beam_trigger_pkg::*;
#(
  parameter int unsigned NBEAMS    = 2,
  parameter string       WBCLKTYPE = "PSCLK",
  parameter string       CLKTYPE   = "ACLK"
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NCHAN-1:0][NSAMP*SAMP_BITS-1:0]   data_i,
  input  logic [POWER_BITS-1:0]                   thresh_i,
  input  logic [NBEAMS-1:0]                       thresh_ce_i,
  input  logic                                    update_i,
  output logic [NBEAMS-1:0]                       trigger_o
);

  word_t             cur_q;
  word_t             prev_q;
  power_t            pend_q  [NBEAMS];
  power_t            act_q   [NBEAMS];
  power_t            beam_pw [NBEAMS];
  logic [NBEAMS-1:0] trig_c;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= data_i;
      prev_q <= cur_q;
    end
  end

  // Update copies the pre-edge pending value, so a same-cycle load waits for the next update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        pend_q[b] <= THRESH_RESET;
        act_q[b]  <= THRESH_RESET;
      end
    end else begin
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        if (thresh_ce_i[b]) pend_q[b] <= thresh_i;
        if (update_i)       act_q[b]  <= pend_q[b];
      end
    end
  end

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    beam_power #(
      .BEAM (b)
    ) u_beam_power (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cur_word  (cur_q),
      .prev_word (prev_q),
      .power     (beam_pw[b])
    );
  end

  always_comb begin
    trig_c = '0;
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      trig_c[b] = beam_pw[b] > act_q[b];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) trigger_o <= '0;
    else         trigger_o <= trig_c;
  end

endmodule

// File: tb/tb_beam_power_trigger.sv
// Self-checking bench for beam_power_trigger: directed scenarios plus randomized traffic vs a stream-level model.
module tb_beam_power_trigger;

  localparam int NB = 2;
  typedef logic [7:0][39:0]   dword_t;
  typedef logic [NB-1:0][17:0] pw_t;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  dword_t         data_i;
  logic [17:0]    thresh_i;
  logic [NB-1:0]  thresh_ce_i;
  logic           update_i;
  logic [NB-1:0]  trigger_o;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // reference model state
  dword_t        prev_m;
  int            pend_m [NB];
  int            act_m  [NB];
  pw_t           pw_q [$];
  logic [NB-1:0] exp_trig;

  beam_power_trigger #(.NBEAMS(NB)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .thresh_i    (thresh_i),
    .thresh_ce_i (thresh_ce_i),
    .update_i    (update_i),
    .trigger_o   (trigger_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int samp(input dword_t w, input int c, input int s);
    logic [39:0] ch;
    logic signed [4:0] v;
    ch = w[c];
    v  = ch[5*s +: 5];
    return int'(v);
  endfunction

  function automatic dword_t fill(input int val);
    dword_t w;
    logic [4:0] v;
    w = '0;
    v = 5'(val);
    for (int c = 0; c < 8; c++)
      for (int s = 0; s < 8; s++)
        w[c][5*s +: 5] = v;
    return w;
  endfunction

  function automatic dword_t impulse_word();
    dword_t w;
    w = '0;
    for (int c = 0; c < 8; c++) w[c][5*(7-c) +: 5] = 5'd15;
    return w;
  endfunction

  function automatic void model_reset();
    prev_m = '0;
    for (int b = 0; b < NB; b++) begin
      pend_m[b] = 32'h3FFFF;
      act_m[b]  = 32'h3FFFF;
    end
    pw_q.delete();
    for (int i = 0; i < 4; i++) pw_q.push_back('0);
    exp_trig = '0;
  endfunction

  // One clock edge: compare the word from four edges ago, then commit thresholds, then add the new word.
  function automatic void model_edge(input dword_t w, input logic [17:0] th,
                                     input logic [NB-1:0] ce, input logic upd);
    pw_t head, p;
    int bs, tot, k;
    head = pw_q.pop_front();
    for (int b = 0; b < NB; b++) exp_trig[b] = int'(head[b]) > act_m[b];
    for (int b = 0; b < NB; b++) if (upd)   act_m[b]  = pend_m[b];
    for (int b = 0; b < NB; b++) if (ce[b]) pend_m[b] = int'(th);
    // stream view: indices 0..7 previous word, 8..15 current word
    for (int b = 0; b < NB; b++) begin
      tot = 0;
      for (int s = 0; s < 8; s++) begin
        bs = 0;
        for (int c = 0; c < 8; c++) begin
          k = 8 + s - ((b * c) % 8);
          bs += (k >= 8) ? samp(w, c, k - 8) : samp(prev_m, c, k);
        end
        tot += bs * bs;
      end
      p[b] = 18'(tot);
    end
    pw_q.push_back(p);
    prev_m = w;
  endfunction

  task automatic step(input dword_t w, input logic [17:0] th,
                      input logic [NB-1:0] ce, input logic upd);
    data_i = w; thresh_i = th; thresh_ce_i = ce; update_i = upd;
    @(posedge clk_i);
    model_edge(w, th, ce, upd);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; data_i = '0; thresh_i = '0; thresh_ce_i = '0; update_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    tests++;
    if (trigger_o !== 2'b00) begin
      fails++; $display("FAIL reset_state: trigger_o=%b expected 00", trigger_o);
    end
    model_reset();
    @(negedge clk_i) rst_ni = 1'b1;
  endtask

  task automatic test_idle_negative();
    for (int i = 0; i < 10; i++) begin
      step(fill(-16), 18'd0, 2'b00, 1'b0);
      tests++;
      if (trigger_o !== 2'b00 || trigger_o !== exp_trig) begin
        fails++; $display("FAIL idle_neg cyc %0d: trigger_o=%b expected 00", cyc, trigger_o);
      end
    end
  endtask

  task automatic test_strict_threshold();
    step(fill(1), 18'd511, 2'b01, 1'b0);
    step(fill(1), 18'd0,   2'b00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(fill(1), 18'd0, 2'b00, 1'b0);
      tests++;
      if (trigger_o !== exp_trig) begin
        fails++; $display("FAIL strict_model cyc %0d: trigger_o=%b expected %b", cyc, trigger_o, exp_trig);
      end
    end
    tests++;
    if (trigger_o[0] !== 1'b1) begin
      fails++; $display("FAIL thresh_511: trigger_o[0]=%b expected 1", trigger_o[0]);
    end
    step(fill(1), 18'd512, 2'b01, 1'b0);
    step(fill(1), 18'd0,   2'b00, 1'b1);
    step(fill(1), 18'd0,   2'b00, 1'b0);
    tests++;
    if (trigger_o[0] !== 1'b0 || trigger_o !== exp_trig) begin
      fails++; $display("FAIL thresh_512_strict: trigger_o=%b expected bit0=0 model %b", trigger_o, exp_trig);
    end
  endtask

  task automatic test_staging();
    step(fill(1), 18'd0, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(fill(1), 18'd0, 2'b00, 1'b0);
      tests++;
      if (trigger_o[1] !== 1'b0 || trigger_o !== exp_trig) begin
        fails++; $display("FAIL ce_no_update cyc %0d: trigger_o=%b expected bit1=0", cyc, trigger_o);
      end
    end
    step(fill(1), 18'd0, 2'b00, 1'b1);
    step(fill(1), 18'd0, 2'b00, 1'b0);
    tests++;
    if (trigger_o[1] !== 1'b1) begin
      fails++; $display("FAIL update_commit: trigger_o[1]=%b expected 1", trigger_o[1]);
    end
    step(fill(1), 18'd600, 2'b10, 1'b0);
    step(fill(1), 18'd0,   2'b10, 1'b1);
    step(fill(1), 18'd0,   2'b00, 1'b0);
    tests++;
    if (trigger_o[1] !== 1'b0 || trigger_o !== exp_trig) begin
      fails++; $display("FAIL same_cycle_old: trigger_o=%b expected bit1=0", trigger_o);
    end
    step(fill(1), 18'd0, 2'b00, 1'b1);
    step(fill(1), 18'd0, 2'b00, 1'b0);
    tests++;
    if (trigger_o[1] !== 1'b1) begin
      fails++; $display("FAIL same_cycle_new_later: trigger_o[1]=%b expected 1", trigger_o[1]);
    end
  endtask

  task automatic test_impulse();
    step(fill(1), 18'd5000, 2'b11, 1'b0);
    step(fill(1), 18'd0,    2'b00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(impulse_word(), 18'd0, 2'b00, 1'b0);
      tests++;
      if (trigger_o !== exp_trig) begin
        fails++; $display("FAIL impulse_model cyc %0d: trigger_o=%b expected %b", cyc, trigger_o, exp_trig);
      end
    end
    tests++;
    if (trigger_o !== 2'b10) begin
      fails++; $display("FAIL impulse_align: trigger_o=%b expected 10", trigger_o);
    end
  endtask

  task automatic test_cross_word();
    dword_t cw;
    logic [NB-1:0] want;
    cw = '0;
    cw[7][30 +: 5] = 5'd15;
    step('0, 18'd224,     2'b10, 1'b0);
    step('0, 18'h3FFFF,   2'b01, 1'b0);
    step('0, 18'd0,       2'b00, 1'b1);
    repeat (5) step('0, 18'd0, 2'b00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      step((i == 0) ? cw : dword_t'('0), 18'd0, 2'b00, 1'b0);
      want = (i == 5) ? 2'b10 : 2'b00;
      tests++;
      if (trigger_o !== want || trigger_o !== exp_trig) begin
        fails++; $display("FAIL cross_word i=%0d: trigger_o=%b expected %b", i, trigger_o, want);
      end
    end
  endtask

  task automatic test_async_reset();
    step(impulse_word(), 18'd5000, 2'b11, 1'b0);
    step(impulse_word(), 18'd0,    2'b00, 1'b1);
    repeat (6) step(impulse_word(), 18'd0, 2'b00, 1'b0);
    tests++;
    if (trigger_o !== 2'b10) begin
      fails++; $display("FAIL pre_reset_trig: trigger_o=%b expected 10", trigger_o);
    end
    #3 rst_ni = 1'b0;
    #1;
    tests++;
    if (trigger_o !== 2'b00) begin
      fails++; $display("FAIL async_reset: trigger_o=%b expected 00", trigger_o);
    end
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(impulse_word(), 18'd0, 2'b00, 1'b0);
      tests++;
      if (trigger_o !== 2'b00 || trigger_o !== exp_trig) begin
        fails++; $display("FAIL post_reset cyc %0d: trigger_o=%b expected 00", cyc, trigger_o);
      end
    end
  endtask

  task automatic test_random();
    dword_t w;
    logic [17:0] th;
    logic [NB-1:0] ce;
    logic upd;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = fill(int'($urandom_range(0, 31)) - 16);
      end else begin
        for (int c = 0; c < 8; c++) w[c] = 40'({$urandom(), $urandom()});
      end
      th  = ($urandom_range(0, 7) == 0) ? 18'($urandom_range(0, 131072)) : 18'($urandom_range(0, 12000));
      ce  = ($urandom_range(0, 2) == 0) ? NB'($urandom_range(1, 3)) : '0;
      upd = ($urandom_range(0, 5) == 0);
      step(w, th, ce, upd);
      tests++;
      if (trigger_o !== exp_trig) begin
        fails++; $display("FAIL random cyc %0d: trigger_o=%b expected %b", cyc, trigger_o, exp_trig);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_negative();
    test_strict_threshold();
    test_staging();
    test_impulse();
    test_cross_word();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
